// File: rtl/soc_system_pio_master.sv
// Avalon-MM master servicing a 1-bit interrupt-capable PIO slave.
// Turns the slave irq into rise/fall events and forwards output-bit writes.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   avm_address/chipselect/  Avalon-MM master side towards the PIO
//   write_n/writedata/
//   readdata/irq
//   cmd_valid/data/ready     local request to drive the PIO output bit
//   evt_valid/level/ready    line-change event towards local logic
//   armed                    mirror of the irq mask last written
module soc_system_pio_master #(
  parameter int unsigned POLL_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_irq,
  input  logic        cmd_valid,
  input  logic        cmd_data,
  output logic        cmd_ready,
  output logic        evt_valid,
  output logic        evt_level,
  input  logic        evt_ready,
  output logic        armed
);

  localparam int CW = $clog2(POLL_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_DIS,
    S_ARM,
    S_EVT
  } state_e;

  state_e          state_q, state_d;
  logic            armed_q, armed_d;
  logic            lvl_q, lvl_d;
  logic            bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;

  logic            tick;
  logic            enter_rd;
  logic            bus_cs;
  logic            bus_wn;
  logic [1:0]      bus_addr;
  logic [31:0]     bus_wd;
  logic            unused_rd;

  assign unused_rd = ^avm_readdata[31:1];

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    lvl_d     = lvl_q;
    bit_d     = bit_q;
    bus_cs    = 1'b0;
    bus_wn    = 1'b1;
    bus_addr  = 2'd0;
    bus_wd    = 32'd0;
    cmd_ready = 1'b0;
    evt_valid = 1'b0;
    enter_rd  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = 2'd2;
        bus_wd   = 32'd1;
        armed_d  = 1'b1;
        state_d  = S_IDLE;
      end
      S_IDLE: begin
        if ((avm_irq && armed_q) || pend_q) begin
          enter_rd = 1'b1;
          state_d  = S_RD;
        end else if (cmd_valid) begin
          cmd_ready = 1'b1;
          bit_d     = cmd_data;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_wd   = {31'd0, bit_q};
        state_d  = S_IDLE;
      end
      S_RD: begin
        bus_cs  = 1'b1;
        state_d = S_CAP;
      end
      S_CAP: begin
        // readdata is registered in the slave: valid one cycle after RD
        if (armed_q && avm_readdata[0]) begin
          state_d = S_DIS;
        end else if (!armed_q && !avm_readdata[0]) begin
          state_d = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIS: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = 2'd2;
        armed_d  = 1'b0;
        lvl_d    = 1'b1;
        state_d  = S_EVT;
      end
      S_ARM: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = 2'd2;
        bus_wd   = 32'd1;
        armed_d  = 1'b1;
        lvl_d    = 1'b0;
        state_d  = S_EVT;
      end
      S_EVT: begin
        evt_valid = 1'b1;
        if (evt_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Free-running poll tick; a tick landing on RD entry re-arms the poll.
  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    pend_d = (pend_q & ~enter_rd) | tick;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      armed_q <= 1'b0;
      lvl_q   <= 1'b0;
      bit_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      lvl_q   <= lvl_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // State sits at INIT during reset; keep the bus quiet until release.
  assign avm_chipselect = bus_cs & reset_n;
  assign avm_write_n    = bus_wn | ~reset_n;
  assign avm_address    = reset_n ? bus_addr : 2'd0;
  assign avm_writedata  = reset_n ? bus_wd : 32'd0;
  assign evt_level      = lvl_q;
  assign armed          = armed_q;

endmodule

// File: tb/tb_soc_system_pio_master.sv
// Bench for soc_system_pio_master: queue-based transaction model,
// per-cycle compare, directed literal checks, then random traffic.
module tb_soc_system_pio_master;

  localparam int unsigned NPOLL = 8;
  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_CAP = 2;
  localparam int K_EVT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_irq;
  logic        cmd_valid;
  logic        cmd_data;
  logic        cmd_ready;
  logic        evt_valid;
  logic        evt_level;
  logic        evt_ready;
  logic        armed;

  soc_system_pio_master #(.POLL_CYCLES(NPOLL)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_irq        (avm_irq),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .evt_valid      (evt_valid),
    .evt_level      (evt_level),
    .evt_ready      (evt_ready),
    .armed          (armed)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h t=%0t", nm, act, exp, $time);
  endtask

  // Model: pending bus/event steps as a queue; empty queue == idle.
  typedef struct {
    int         kind;
    logic [1:0] addr;
    logic       d;
    logic       ev;
  } step_t;

  step_t q[$];
  logic  m_armed;
  logic  m_lvl;
  logic  m_pend;
  int    m_cnt;

  always @(posedge clk) begin
    step_t h;
    bit    tk;
    bit    ent;
    if (!reset_n) begin
      q.delete();
      q.push_back('{K_WR, 2'd2, 1'b1, 1'b0});
      m_armed = 1'b0;
      m_lvl   = 1'b0;
      m_pend  = 1'b0;
      m_cnt   = 0;
    end else begin
      tk    = (m_cnt == NPOLL - 1);
      m_cnt = (m_cnt + 1) % NPOLL;
      ent   = 1'b0;
      if (q.size() == 0) begin
        if ((avm_irq && m_armed) || m_pend) begin
          q.push_back('{K_RD, 2'd0, 1'b0, 1'b0});
          q.push_back('{K_CAP, 2'd0, 1'b0, 1'b0});
          ent = 1'b1;
        end else if (cmd_valid) begin
          q.push_back('{K_WR, 2'd0, cmd_data, 1'b0});
        end
      end else begin
        h = q[0];
        case (h.kind)
          K_WR: begin
            void'(q.pop_front());
            if (h.addr == 2'd2) m_armed = h.d;
            if (h.ev) m_lvl = ~h.d;
          end
          K_RD: void'(q.pop_front());
          K_CAP: begin
            void'(q.pop_front());
            if (m_armed && avm_readdata[0]) begin
              q.push_back('{K_WR, 2'd2, 1'b0, 1'b1});
              q.push_back('{K_EVT, 2'd0, 1'b0, 1'b0});
            end else if (!m_armed && !avm_readdata[0]) begin
              q.push_back('{K_WR, 2'd2, 1'b1, 1'b1});
              q.push_back('{K_EVT, 2'd0, 1'b0, 1'b0});
            end
          end
          default: if (evt_ready) void'(q.pop_front());
        endcase
      end
      m_pend = (m_pend && !ent) || tk;
    end
  end

  // Per-cycle compare against the model
  always begin
    logic [39:0] act;
    logic [39:0] exp;
    logic        cs, wn, cr, ev;
    logic [1:0]  ad;
    logic [31:0] wd;
    @(negedge clk);
    #2;
    act = {avm_chipselect, avm_write_n, avm_address, avm_writedata,
           cmd_ready, evt_valid, evt_level, armed};
    cs = 1'b0; wn = 1'b1; ad = 2'd0; wd = 32'd0; cr = 1'b0; ev = 1'b0;
    if (!reset_n) begin
      exp = {1'b0, 1'b1, 2'd0, 32'd0, 4'd0};
    end else begin
      if (q.size() == 0) begin
        cr = cmd_valid && !(avm_irq && m_armed) && !m_pend;
      end else begin
        case (q[0].kind)
          K_WR: begin
            cs = 1'b1; wn = 1'b0; ad = q[0].addr; wd = {31'd0, q[0].d};
          end
          K_RD: cs = 1'b1;
          K_EVT: ev = 1'b1;
          default: ;
        endcase
      end
      exp = {cs, wn, ad, wd, cr, ev, m_lvl, m_armed};
    end
    chk("model", act, exp);
  end

  // Bench-side PIO slave mask, used for realistic irq in random traffic
  logic smask = 1'b0;
  always @(posedge clk)
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
      smask <= avm_writedata[0];

  task automatic wait_evt(input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk); #3;
      if (evt_valid) hit = 1'b1;
    end
    chk(nm, 40'(hit), 40'd1);
  endtask

  task automatic wait_rdy(input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk); #3;
      if (cmd_ready) hit = 1'b1;
    end
    chk(nm, 40'(hit), 40'd1);
  endtask

  task automatic chk_init(input string nm);
    chk({nm, "_cs"}, 40'(avm_chipselect), 40'd1);
    chk({nm, "_wn"}, 40'(avm_write_n), 40'd0);
    chk({nm, "_ad"}, 40'(avm_address), 40'd2);
    chk({nm, "_wd"}, 40'(avm_writedata), 40'd1);
  endtask

  initial begin
    logic        line;
    logic [31:0] r;
    reset_n      = 1'b0;
    avm_readdata = 32'd0;
    avm_irq      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_data     = 1'b0;
    evt_ready    = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_cs", 40'(avm_chipselect), 40'd0);
    chk("rst_evt", 40'(evt_valid), 40'd0);
    chk("rst_armed", 40'(armed), 40'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #3;
    chk_init("init");
    @(negedge clk); #3;
    chk("init_armed", 40'(armed), 40'd1);
    chk("init_idle", 40'(avm_chipselect), 40'd0);

    // Rise while armed
    avm_irq = 1'b1;
    avm_readdata = 32'd1;
    wait_evt("rise_to");
    chk("rise_lvl", 40'(evt_level), 40'd1);
    @(negedge clk); #3;
    chk("rise_done", 40'(evt_valid), 40'd0);
    chk("rise_armed", 40'(armed), 40'd0);

    // Fall found by polling
    avm_irq = 1'b0;
    avm_readdata = 32'd0;
    wait_evt("fall_to");
    chk("fall_lvl", 40'(evt_level), 40'd0);
    @(negedge clk); #3;
    chk("fall_armed", 40'(armed), 40'd1);

    // Spurious irq while armed
    avm_irq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #3;
      chk("spur_evt", 40'(evt_valid), 40'd0);
    end
    chk("spur_armed", 40'(armed), 40'd1);
    avm_irq = 1'b0;

    // Backpressure on the event
    evt_ready = 1'b0;
    avm_irq = 1'b1;
    avm_readdata = 32'd1;
    wait_evt("bp_to");
    cmd_valid = 1'b1;
    cmd_data  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      chk("bp_hold", 40'({evt_valid, evt_level, avm_chipselect, cmd_ready}),
          40'b1100);
    end
    evt_ready = 1'b1;
    @(negedge clk); #3;
    chk("bp_rel", 40'(evt_valid), 40'd0);

    // Command write
    wait_rdy("cmd_to");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk); #3;
    chk("cmd_wr", 40'({avm_chipselect, avm_write_n, avm_address}),
        40'b1000);
    chk("cmd_wd", 40'(avm_writedata), 40'h1);

    // irq and cmd together: irq first
    avm_irq = 1'b0;
    avm_readdata = 32'd0;
    wait_evt("rearm_to");
    avm_irq = 1'b1;
    avm_readdata = 32'd1;
    cmd_valid = 1'b1;
    cmd_data  = 1'b0;
    @(negedge clk); #3;
    chk("prio_rdy", 40'(cmd_ready), 40'd0);
    @(negedge clk); #3;
    chk("prio_rd", 40'({avm_chipselect, avm_write_n, avm_address}),
        40'b1100);
    wait_evt("prio_evt");
    wait_rdy("prio_cmd");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk); #3;
    chk("prio_wr", 40'({avm_chipselect, avm_write_n, avm_writedata[0]}),
        40'b100);

    // Reset in the middle of a held event
    evt_ready = 1'b0;
    avm_irq = 1'b0;
    avm_readdata = 32'd0;
    wait_evt("mid_to");
    reset_n = 1'b0;
    #1;
    chk("mid_evt", 40'({evt_valid, avm_chipselect, armed}), 40'd0);
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #3;
    chk_init("reinit");

    // Random traffic against the model
    line = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) line = ~line;
      r = $urandom;
      r[0] = line;
      avm_readdata = r;
      avm_irq   = (line & smask) | ($urandom_range(0, 29) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_data  = 1'($urandom);
      evt_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    evt_ready = 1'b1;
    repeat (4) @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/soc_system_pio_master.md
Name: soc_system_pio_master

Overview:
- Avalon-MM master that services a 1-bit interrupt-capable PIO slave (data register at address 0, irq-mask register at address 2, readdata registered, no waitrequest).
- Turns the slave's level-sensitive irq into debounced rise/fall events for local logic, using an arm/disarm mask scheme plus periodic polling.
- Forwards single-bit output writes from local logic to the slave's data register.
- Sits between fabric-side control logic and one PIO instance.

Parameters:
POLL_CYCLES, 1000, period in clk cycles of the poll tick used to detect line release while disarmed; legal range >= 2.

Ports:
clk  input  1  system clock; all logic rising-edge
reset_n  input  1  asynchronous active-low reset
avm_address  output  2  slave register select
avm_chipselect  output  1  bus cycle strobe, one cycle per access
avm_write_n  output  1  active-low write qualifier
avm_writedata  output  32  write data; bits 31:1 always 0
avm_readdata  input  32  slave readdata; only bit 0 used
avm_irq  input  1  slave interrupt, level
cmd_valid  input  1  local request to drive slave output bit
cmd_data  input  1  value to write to slave data register
cmd_ready  output  1  one-cycle accept pulse for cmd
evt_valid  output  1  line-change event pending
evt_level  output  1  new line level carried by event (1 rise, 0 fall)
evt_ready  input  1  event consumer accept
armed  output  1  mirror of the mask value last written to the slave

Behaviour:
- Reset (async assert, sync effect on deassert): state=INIT; avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, cmd_ready=0, evt_valid=0, evt_level=0, armed=0, poll counter=0, poll_pending=0. Reset mid-transaction abandons it; no completion is emitted.
- Bus rules: every access is exactly one cycle with avm_chipselect=1. Write: avm_write_n=0. Read: avm_write_n=1, address 0. The read value is sampled from avm_readdata[0] in the cycle immediately after the read cycle (latency 1). Outside accesses: avm_chipselect=0, avm_write_n=1.
- Poll counter: free-running from 0 to POLL_CYCLES-1, then wraps to 0. A tick at the wrap sets poll_pending. poll_pending clears when state RD is entered. Ticks while pending are absorbed.
- FSM states and transitions:
  - INIT: write address 2, data 1; armed<=1; next state IDLE.
  - IDLE: priority 1: avm_irq&&armed goes to RD. Priority 2: poll_pending goes to RD. Priority 3: cmd_valid goes to WR (cmd_ready pulses 1 in this IDLE cycle; cmd_data is latched).
  - WR: write address 0, data {31'b0,latched bit}; next state IDLE.
  - RD: read cycle; next state CAP.
  - CAP: sample s=avm_readdata[0].
    - armed&&s=1: go to DIS.
    - !armed&&s=0: go to ARM.
    - Otherwise (spurious irq, or line still high while disarmed): go to IDLE, no event.
  - DIS: write address 2, data 0; armed<=0; evt_level<=1; next state EVT.
  - ARM: write address 2, data 1; armed<=1; evt_level<=0; next state EVT.
  - EVT: evt_valid=1, held with evt_level stable until evt_ready=1; leaves to IDLE on the same cycle evt_ready=1 (evt_valid=0 next cycle). No bus activity and no cmd acceptance while in EVT (backpressure stalls everything).
- Simultaneous irq and cmd_valid in IDLE: irq wins; cmd waits (cmd_ready=0). Simultaneous poll_pending and cmd: poll wins.
- Worst-case command latency: RD+CAP+DIS/ARM+EVT (consumer-dependent) plus IDLE.
- Polling always runs, but reads while armed with s=0 are no-ops.

Test Plan:
- Reset release -> first cycle after reset: chipselect=1, write_n=0, address=2, writedata=1; armed=1; then bus idle.
- irq=1 with readdata[0]=1, evt_ready=1 -> RD (address 0, write_n=1), CAP, write address 2 data 0, then evt_valid=1 with evt_level=1 for one cycle; armed=0; irq ignored afterwards.
- Disarmed, line drops to 0, POLL_CYCLES=8 -> within 8 cycles a read occurs, then write address 2 data 1, event evt_level=0, armed=1.
- cmd_valid=1, cmd_data=1 in IDLE with no irq/poll -> cmd_ready pulse, next cycle write address 0 writedata=32'h1; irq and cmd together -> irq serviced first.
- evt_ready=0 for 20 cycles during EVT -> evt_valid and evt_level held, no bus cycles, cmd_ready=0; release -> returns to IDLE.
- Spurious irq (readdata[0]=0 while armed) -> no event, armed stays 1. reset_n=0 mid-EVT -> evt_valid=0 immediately, then INIT mask write.
